// File: rtl/uart_pkg.sv
// Shared UART definitions: receiver state encoding, parity modes and the
// 16x oversampling divider calculation.
package uart_pkg;

  typedef enum logic [2:0] {
    RX_IDLE,
    RX_START,
    RX_DATA,
    RX_PARITY,
    RX_STOP
  } rx_state_t;

  localparam int PAR_NONE = 0;
  localparam int PAR_EVEN = 1;
  localparam int PAR_ODD  = 2;

  // Clocks per 16x sample tick, truncated; must come out >= 2.
  function automatic int calc_div(input int clk_freq, input int baud_rate);
    return clk_freq / (baud_rate * 16);
  endfunction

  // Parity error for a received byte plus its parity bit.
  function automatic logic par_error(input int mode, input logic [7:0] data,
                                     input logic pbit);
    logic x;
    x = ^{data, pbit};
    case (mode)
      PAR_EVEN: return x;
      PAR_ODD:  return ~x;
      default:  return 1'b0;
    endcase
  endfunction

endpackage

// File: rtl/uart_baud_tick.sv
// 16x oversampling tick: one-clk pulse every DIV clocks, restartable so the
// sample grid can be aligned to an external event.
module uart_baud_tick #(
  parameter int DIV = 6
) (
  input  logic clk,
  input  logic rst,
  input  logic clr,
  output logic tick
);

  localparam int CW = (DIV > 1) ? $clog2(DIV) : 1;

  logic [CW-1:0] cnt;

  assign tick = (cnt == CW'(DIV - 1));

  // Divider counter 0..DIV-1; clr restarts it from zero.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)             cnt <= '0;
    else if (clr || tick) cnt <= '0;
    else                  cnt <= cnt + 1'b1;
  end

endmodule

// File: rtl/uart_rx_os16.sv
// 16x oversampling UART receiver with 3-sample majority vote, false-start
// rejection, optional parity check and stop-bit framing check.
//
//   state     | meaning
//   ----------+-------------------------------------------------------------
//   RX_IDLE   | waiting for a falling edge on rx_s (only once armed)
//   RX_START  | validating the start bit; majority 1 at sample 9 = glitch
//   RX_DATA   | shifting in 8 data bits, LSB first, at sample 9 of each bit
//   RX_PARITY | capturing the parity bit at sample 9
//   RX_STOP   | checking the stop bit at sample 9, then publishing the byte
module uart_rx_os16
  import uart_pkg::*;
#(
  parameter int CLK_FREQ  = 1000000,
  parameter int BAUD_RATE = 9600,
  parameter int PARITY    = 0
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       rx,
  output logic [7:0] dout,
  output logic       done,
  output logic       ferr,
  output logic       perr,
  output logic       busy
);

  localparam int DIV = calc_div(CLK_FREQ, BAUD_RATE);

  rx_state_t  state, state_nx;
  logic       rx_m, rx_s;
  logic [1:0] sync_fill;
  logic       armed;
  logic       tick, start_det, finish;
  logic [3:0] samp;
  logic [2:0] bit_idx;
  logic       v7, v8, vote;
  logic       at_mid, at_end;
  logic [7:0] shreg;
  logic       par_bit;

  uart_baud_tick #(.DIV(DIV)) u_tick (
    .clk  (clk),
    .rst  (rst),
    .clr  (start_det),
    .tick (tick)
  );

  // Samples 7 and 8 are held; sample 9 is the live rx_s at the deciding tick.
  assign vote   = (v7 & v8) | (v7 & rx_s) | (v8 & rx_s);
  assign at_mid = tick && (samp == 4'd9);
  assign at_end = tick && (samp == 4'd15);
  assign busy   = (state != RX_IDLE);

  // Two-flop synchronizer; sync_fill marks when rx_s carries real line data
  // rather than its reset value, so a line held low through reset never arms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      rx_m      <= 1'b1;
      rx_s      <= 1'b1;
      sync_fill <= 2'b00;
    end else begin
      rx_m      <= rx;
      rx_s      <= rx_m;
      sync_fill <= {sync_fill[0], 1'b1};
    end
  end

  // State register.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) state <= RX_IDLE;
    else      state <= state_nx;
  end

  // Next-state logic plus the start-detect and frame-complete strobes.
  always_comb begin
    state_nx  = state;
    start_det = 1'b0;
    finish    = 1'b0;
    case (state)
      RX_IDLE: begin
        if (armed && !rx_s) begin
          state_nx  = RX_START;
          start_det = 1'b1;
        end
      end
      RX_START: begin
        if (at_mid && vote) state_nx = RX_IDLE;
        else if (at_end)    state_nx = RX_DATA;
      end
      RX_DATA: begin
        if (at_end && bit_idx == 3'd7)
          state_nx = (PARITY != PAR_NONE) ? RX_PARITY : RX_STOP;
      end
      RX_PARITY: begin
        if (at_end) state_nx = RX_STOP;
      end
      RX_STOP: begin
        // Leave mid-stop-bit so a back-to-back start edge is not missed.
        if (at_mid) begin
          state_nx = RX_IDLE;
          finish   = 1'b1;
        end
      end
      default: state_nx = RX_IDLE;
    endcase
  end

  // Sample position, mid-bit votes, data shift register and parity capture.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      samp    <= '0;
      bit_idx <= '0;
      v7      <= 1'b1;
      v8      <= 1'b1;
      shreg   <= '0;
      par_bit <= 1'b0;
    end else begin
      if (start_det) begin
        samp    <= '0;
        bit_idx <= '0;
      end else if (tick) begin
        samp <= samp + 1'b1;
        if (state == RX_DATA && samp == 4'd15) bit_idx <= bit_idx + 1'b1;
      end
      if (tick && samp == 4'd7) v7 <= rx_s;
      if (tick && samp == 4'd8) v8 <= rx_s;
      if (state == RX_DATA && at_mid)   shreg   <= {vote, shreg[7:1]};
      if (state == RX_PARITY && at_mid) par_bit <= vote;
    end
  end

  // Arming: needs a real high on the line; a zero stop bit (break) disarms.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst)                                         armed <= 1'b0;
    else if (finish)                                  armed <= vote;
    else if (state == RX_IDLE && rx_s && sync_fill[1]) armed <= 1'b1;
  end

  // Published results, held until the next completed frame.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      dout <= '0;
      done <= 1'b0;
      ferr <= 1'b0;
      perr <= 1'b0;
    end else begin
      done <= finish;
      if (finish) begin
        dout <= shreg;
        ferr <= ~vote;
        perr <= par_error(PARITY, shreg, par_bit);
      end
    end
  end

endmodule

// File: tb/tb_uart_rx_os16.sv
// Bench for uart_rx_os16: u0 without parity, u1 with even parity.
// A frame queue per receiver holds the result each sent frame must produce;
// one compare process checks every cycle against it.
module tb_uart_rx_os16;

  localparam int DIV     = 1000000 / (9600 * 16);
  localparam int BIT_CLK = 16 * DIV;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic       rx0 = 1'b1;
  logic       rx1 = 1'b1;
  logic [7:0] dout0, dout1;
  logic       done0, done1, ferr0, ferr1, perr0, perr1, busy0, busy1;

  int n_chk  = 0;
  int n_pass = 0;
  int cyc    = 0;

  typedef struct {
    logic [7:0] data;
    logic       ferr;
    logic       perr;
    int         t0;
    int         lat;
  } exp_t;

  exp_t       q0[$];
  exp_t       q1[$];
  logic [9:0] last0 = '0;
  logic [9:0] last1 = '0;

  uart_rx_os16 #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .PARITY(0)) u0 (
    .clk(clk), .rst(rst), .rx(rx0), .dout(dout0), .done(done0),
    .ferr(ferr0), .perr(perr0), .busy(busy0)
  );

  uart_rx_os16 #(.CLK_FREQ(1000000), .BAUD_RATE(9600), .PARITY(1)) u1 (
    .clk(clk), .rst(rst), .rx(rx1), .dout(dout1), .done(done1),
    .ferr(ferr1), .perr(perr1), .busy(busy1)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h, expected %0h", name, act, exp);
  endtask

  task automatic chk_range(input string name, input int act, input int lo, input int hi);
    n_chk++;
    if (act >= lo && act <= hi) n_pass++;
    else $display("FAIL %s: got %0d, expected %0d..%0d", name, act, lo, hi);
  endtask

  // Per-cycle comparison of one receiver against its frame queue.
  task automatic scan(input int ch, input logic d, input logic [7:0] dq,
                      input logic fe, input logic pe, input logic bz);
    exp_t       e;
    logic [9:0] last;
    int         qn;
    last = (ch == 0) ? last0 : last1;
    qn   = (ch == 0) ? q0.size() : q1.size();
    if (!rst) begin
      chk($sformatf("u%0d outputs in reset", ch), {20'h0, dq, fe, pe, d, bz}, 32'h0);
      last = '0;
      if (ch == 0) q0.delete();
      else         q1.delete();
    end else if (d) begin
      chk($sformatf("u%0d busy at done", ch), {31'h0, bz}, 32'h0);
      if (qn == 0) begin
        n_chk++;
        $display("FAIL u%0d unexpected done: dout %0h, expected no frame", ch, dq);
      end else begin
        if (ch == 0) e = q0.pop_front();
        else         e = q1.pop_front();
        chk($sformatf("u%0d dout", ch), {24'h0, dq}, {24'h0, e.data});
        chk($sformatf("u%0d ferr", ch), {31'h0, fe}, {31'h0, e.ferr});
        chk($sformatf("u%0d perr", ch), {31'h0, pe}, {31'h0, e.perr});
        chk_range($sformatf("u%0d latency", ch), cyc - e.t0, e.lat - DIV, e.lat + 2 * DIV);
        last = {e.data, e.ferr, e.perr};
      end
    end else begin
      chk($sformatf("u%0d held outputs", ch), {22'h0, dq, fe, pe}, {22'h0, last});
    end
    if (ch == 0) last0 = last;
    else         last1 = last;
  endtask

  always @(negedge clk) begin
    scan(0, done0, dout0, ferr0, perr0, busy0);
    scan(1, done1, dout1, ferr1, perr1, busy1);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic set_rx(input int ch, input logic v);
    if (ch == 0) rx0 = v;
    else         rx1 = v;
  endtask

  // Drives one frame bit by bit. glitch_bit inverts 6 clk around the middle
  // of that data bit; abort_bit returns mid-way through that data bit and the
  // frame is not expected to complete.
  task automatic send_frame(input int ch, input logic [7:0] data, input logic stop_val,
                            input logic par_flip, input int glitch_bit, input int abort_bit);
    logic [10:0] frame;
    int          nb;
    logic        pbit;
    logic        line;
    exp_t        e;
    pbit  = (($countones(data) % 2) == 1) ^ par_flip;
    frame = '1;
    frame[0]   = 1'b0;
    frame[8:1] = data;
    if (ch == 1) begin
      frame[9]  = pbit;
      frame[10] = stop_val;
      nb        = 11;
    end else begin
      frame[9] = stop_val;
      nb       = 10;
    end
    e.data = data;
    e.ferr = ~stop_val;
    e.perr = (ch == 1) ? ((($countones(data) + int'(pbit)) % 2) == 1) : 1'b0;
    e.t0   = cyc;
    e.lat  = (9 + 16 * (nb - 1)) * DIV + 2;
    if (abort_bit < 0) begin
      if (ch == 0) q0.push_back(e);
      else         q1.push_back(e);
    end
    for (int b = 0; b < nb; b++) begin
      for (int c = 0; c < BIT_CLK; c++) begin
        if (abort_bit >= 0 && b == abort_bit + 1 && c == BIT_CLK / 2) return;
        line = frame[b];
        if (glitch_bit >= 0 && b == glitch_bit + 1 && c >= 51 && c <= 56) line = ~line;
        set_rx(ch, line);
        tick(1);
      end
    end
  endtask

  task automatic wait_drain(input int ch, input int budget);
    int qn;
    qn = (ch == 0) ? q0.size() : q1.size();
    for (int i = 0; i < budget && qn != 0; i++) begin
      tick(1);
      qn = (ch == 0) ? q0.size() : q1.size();
    end
    chk($sformatf("u%0d frames outstanding", ch), qn, 0);
  endtask

  initial begin
    int n;
    int hi;

    tick(4);
    chk("reset dout", {24'h0, dout0}, 32'h0);
    chk("reset busy", {31'h0, busy0}, 32'h0);
    rst = 1'b1;
    tick(6);

    // Plain frame, no parity.
    send_frame(0, 8'hA5, 1'b1, 1'b0, -1, -1);
    wait_drain(0, 200);
    chk("A5 dout", {24'h0, dout0}, 32'hA5);
    chk("A5 ferr", {31'h0, ferr0}, 32'h0);
    chk("A5 perr", {31'h0, perr0}, 32'h0);
    chk("A5 busy after done", {31'h0, busy0}, 32'h0);
    tick(20);

    // 12-clk low pulse: start detected, then rejected at the vote.
    rx0 = 1'b0;
    tick(12);
    chk("false start busy", {31'h0, busy0}, 32'h1);
    rx0 = 1'b1;
    n = 0;
    while (busy0 && n < 10 * DIV) begin
      tick(1);
      n++;
    end
    chk("false start busy release", {31'h0, busy0}, 32'h0);
    tick(2 * BIT_CLK);
    chk("false start dout kept", {24'h0, dout0}, 32'hA5);

    // Zero stop bit, line left low afterwards: a break must not retrigger.
    send_frame(0, 8'h3C, 1'b0, 1'b0, -1, -1);
    wait_drain(0, 200);
    chk("break dout", {24'h0, dout0}, 32'h3C);
    chk("break ferr", {31'h0, ferr0}, 32'h1);
    hi = 0;
    repeat (300) begin
      tick(1);
      if (busy0) hi++;
    end
    chk("break ignored busy cycles", hi, 0);
    rx0 = 1'b1;
    tick(20);
    send_frame(0, 8'h81, 1'b1, 1'b0, -1, -1);
    wait_drain(0, 200);
    chk("after break dout", {24'h0, dout0}, 32'h81);
    chk("after break ferr", {31'h0, ferr0}, 32'h0);

    // Even parity: 0x3C has four ones, so a parity bit of 0 is correct.
    send_frame(1, 8'h3C, 1'b1, 1'b0, -1, -1);
    wait_drain(1, 200);
    chk("even good dout", {24'h0, dout1}, 32'h3C);
    chk("even good perr", {31'h0, perr1}, 32'h0);
    tick(20);
    send_frame(1, 8'h3C, 1'b1, 1'b1, -1, -1);
    wait_drain(1, 200);
    chk("even bad perr", {31'h0, perr1}, 32'h1);
    chk("even bad ferr", {31'h0, ferr1}, 32'h0);
    tick(20);

    // Back-to-back frames, glitch on the middle sample of data bit 3.
    send_frame(0, 8'h00, 1'b1, 1'b0, -1, -1);
    chk("b2b first dout", {24'h0, dout0}, 32'h00);
    send_frame(0, 8'hFF, 1'b1, 1'b0, 3, -1);
    wait_drain(0, 200);
    chk("b2b glitch dout", {24'h0, dout0}, 32'hFF);
    tick(20);

    // Reset during data bit 4; line held low across reset release.
    send_frame(0, 8'h96, 1'b1, 1'b0, -1, 4);
    #2;
    rst = 1'b0;
    rx0 = 1'b0;
    #1;
    chk("async reset dout", {24'h0, dout0}, 32'h0);
    chk("async reset busy", {31'h0, busy0}, 32'h0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    hi = 0;
    repeat (200) begin
      tick(1);
      if (busy0) hi++;
    end
    chk("low through reset busy cycles", hi, 0);
    rx0 = 1'b1;
    tick(20);
    send_frame(0, 8'h5A, 1'b1, 1'b0, -1, -1);
    wait_drain(0, 200);
    chk("after reset dout", {24'h0, dout0}, 32'h5A);
    tick(10);

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
